// File: rtl/fifo_rd_packer.sv
// fifo_rd_packer
// Read-domain consumer for an asynchronous FIFO. It pops bytes through a
// first-word-fall-through read port and packs them little-endian into 32-bit
// words. The words leave on a valid/ready stream. A flush request emits any
// partial word with a byte-keep mask. A running counter tracks how many
// bytes have been popped.
//
// Ports:
//   rclk, rrst          read-domain clock, synchronous active-high reset
//   en                  consume enable; low stops new pops
//   rempty, rdata       FIFO empty flag and head byte (FWFT)
//   rinc                pop strobe; the byte is taken at the edge where it is 1
//   flush, flush_done   partial-word flush request / completion pulse
//   m_data, m_keep      packed word (byte0 in [7:0]) and valid lanes
//   m_valid, m_ready    output stream handshake
//   bytes_read          bytes popped since reset, wraps modulo 2^CNT_W
//   busy                partial bytes held, word pending, or flush pending
//
// Optional build macro INCR_CHECK_EN adds seq_err_cnt. This 8-bit saturating
// count records popped bytes that do not follow the previous byte plus one.

module fifo_rd_packer #(
  parameter int KEEP_W = 4,
  parameter int CNT_W  = 16
) (
  input  logic                  rclk,
  input  logic                  rrst,
  input  logic                  en,
  input  logic                  rempty,
  input  logic [7:0]            rdata,
  output logic                  rinc,
  input  logic                  flush,
  output logic                  flush_done,
  output logic [8*KEEP_W-1:0]   m_data,
  output logic [KEEP_W-1:0]     m_keep,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [CNT_W-1:0]      bytes_read,
  output logic                  busy
`ifdef INCR_CHECK_EN
  ,
  output logic [7:0]            seq_err_cnt
`endif
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] FLUSH = 2'd2;

  logic [1:0]            state;
  logic [23:0]           pack;
  logic [1:0]            pack_cnt;
  logic                  out_free;
  logic                  flush_load;
  logic [8*KEEP_W-1:0]   partial_data;
  logic [KEEP_W-1:0]     partial_keep;

  assign out_free = !m_valid || m_ready;

  // A fourth byte completes a word, so it may only be popped when the output
  // register can take that word in the same edge.
  assign rinc = !rrst && (state == RUN) && !rempty &&
                ((pack_cnt != 2'd3) || out_free);

  // The flush finishes in the cycle that loads the partial word. With nothing
  // buffered, it finishes immediately.
  assign flush_done = !rrst && (state == FLUSH) &&
                      ((pack_cnt == 2'd0) || out_free);
  assign flush_load = flush_done && (pack_cnt != 2'd0);

  assign busy = (pack_cnt != 2'd0) || m_valid || (state == FLUSH);

  // Stale bytes from earlier words remain in the upper pack lanes. The
  // partial word therefore zeroes every lane at or above pack_cnt.
  always_comb begin
    partial_data = '0;
    partial_keep = '0;
    case (pack_cnt)
      2'd1: begin
        partial_data = {24'h0, pack[7:0]};
        partial_keep = 4'b0001;
      end
      2'd2: begin
        partial_data = {16'h0, pack[15:0]};
        partial_keep = 4'b0011;
      end
      2'd3: begin
        partial_data = {8'h0, pack};
        partial_keep = 4'b0111;
      end
      default: ;
    endcase
  end

  // A flush request wins over enable changes and moves any state to FLUSH.
  // Requests are ignored while a flush is already pending.
  always_ff @(posedge rclk) begin
    if (rrst) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (flush) state <= FLUSH;
                 else if (en) state <= RUN;
        RUN:     if (flush) state <= FLUSH;
                 else if (!en) state <= IDLE;
        FLUSH:   if (flush_done) state <= en ? RUN : IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Packing and output register. An accepted word clears m_valid first. A
  // load in the same edge (full word or flushed partial) then overrides that
  // clear. Pops and flush loads never coincide because pops only happen in
  // RUN.
  always_ff @(posedge rclk) begin
    if (rrst) begin
      pack       <= '0;
      pack_cnt   <= 2'd0;
      m_data     <= '0;
      m_keep     <= '0;
      m_valid    <= 1'b0;
      bytes_read <= '0;
    end else begin
      if (m_valid && m_ready) begin
        m_valid <= 1'b0;
      end
      if (rinc) begin
        bytes_read <= bytes_read + 1'b1;
        if (pack_cnt == 2'd3) begin
          m_data   <= {rdata, pack};
          m_keep   <= '1;
          m_valid  <= 1'b1;
          pack_cnt <= 2'd0;
        end else begin
          pack[8*pack_cnt +: 8] <= rdata;
          pack_cnt              <= pack_cnt + 1'b1;
        end
      end else if (flush_load) begin
        m_data   <= partial_data;
        m_keep   <= partial_keep;
        m_valid  <= 1'b1;
        pack_cnt <= 2'd0;
      end
    end
  end

`ifdef INCR_CHECK_EN
  logic       seeded;
  logic [7:0] expect_byte;

  // The first byte after reset only seeds the expectation. Every later pop
  // is compared against it, and the expectation always re-seeds from the
  // byte just popped.
  always_ff @(posedge rclk) begin
    if (rrst) begin
      seeded      <= 1'b0;
      expect_byte <= 8'h00;
      seq_err_cnt <= 8'h00;
    end else if (rinc) begin
      seeded      <= 1'b1;
      expect_byte <= rdata + 8'd1;
      if (seeded && (rdata != expect_byte) && (seq_err_cnt != 8'hFF)) begin
        seq_err_cnt <= seq_err_cnt + 8'd1;
      end
    end
  end
`endif

endmodule
